idivider_radix: RTL and testbench

Parametrised multicycle signed/unsigned integer divider and successor to the single-bit restoring divider in the CPU multicycle ALU ops. It retires BITS_PER_CYCLE quotient bits per clock. It handles divide-by-zero and signed overflow in a fixed single cycle, supports abort on pipeline flush, and presents a busy/done handshake to the execute stage.

---
 rtl/idivider_pkg.sv | 25 ++
 rtl/idivider_step.sv | 24 ++
 rtl/idivider_radix.sv | 197 +++++++++++++++++++
 tb/tb_idivider_radix.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/idivider_pkg.sv
// rtl/idivider_pkg.sv - shared types and sizing helpers for the radix-2^k integer divider
package idivider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } idiv_state_t;

    // Number of CALC cycles needed to retire all quotient bits.
    function automatic int iter_of(input int data_width, input int bits_per_cycle);
        return data_width / bits_per_cycle;
    endfunction

    // The counter must be able to hold ITER itself (early termination may start there).
    function automatic int count_width_of(input int iter);
        return (iter < 2) ? 1 : $clog2(iter + 1);
    endfunction

    function automatic bit bpc_legal(input int data_width, input int bits_per_cycle);
        return ((bits_per_cycle == 1) || (bits_per_cycle == 2) || (bits_per_cycle == 4)) &&
               ((data_width % bits_per_cycle) == 0);
    endfunction

endpackage

// File: rtl/idivider_step.sv
// rtl/idivider_step.sv - one combinational restoring-division step
module idivider_step
    import idivider_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] remainder,
    input  logic                  quotient_msb,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] remainder_next,
    output logic                  quotient_bit
);

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH+1:0] trial;

    assign shifted = {remainder, quotient_msb};
    assign trial   = {1'b0, shifted} - {2'b00, divisor};

    // A clear borrow means the divisor fit; the difference is then below the divisor.
    assign quotient_bit   = ~trial[DATA_WIDTH+1];
    assign remainder_next = quotient_bit ? DATA_WIDTH'(trial) : DATA_WIDTH'(shifted);

endmodule

// File: rtl/idivider_radix.sv
// rtl/idivider_radix.sv - multicycle signed/unsigned divider, optional IDIVIDER_EARLY_TERM_EN
module idivider_radix
    import idivider_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  is_signed,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] y_quotient,
    output logic [DATA_WIDTH-1:0] y_remainder,
    output logic                  done
);

    localparam int ITER = iter_of(DATA_WIDTH, BITS_PER_CYCLE);
    localparam int CW   = count_width_of(ITER);
    localparam logic [CW-1:0]         LAST_COUNT = CW'(ITER - 1);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [DATA_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    if (!bpc_legal(DATA_WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
        $error("idivider_radix: illegal BITS_PER_CYCLE / DATA_WIDTH combination");
    end

    idiv_state_t state, next_state;

    logic [DATA_WIDTH-1:0] quotient_sr;
    logic [DATA_WIDTH-1:0] remainder;
    logic [DATA_WIDTH-1:0] divisor_r;
    logic [CW-1:0]         count;
    logic                  dividend_neg;
    logic                  divisor_neg;

    logic                  a_neg, b_neg;
    logic [DATA_WIDTH-1:0] abs_a, abs_b;
    logic                  div_zero, signed_ovf, special;
    logic                  accept;
    logic [CW-1:0]         start_count;
    logic [DATA_WIDTH-1:0] start_qsr;
    logic                  early_zero;

    logic                  load, special_done, calc_en, finish;

    always_comb begin
        a_neg      = is_signed & a[DATA_WIDTH-1];
        b_neg      = is_signed & b[DATA_WIDTH-1];
        abs_a      = a_neg ? -a : a;
        abs_b      = b_neg ? -b : b;
        div_zero   = (b == '0);
        signed_ovf = is_signed && (a == SIGNED_MIN) && (b == ALL_ONES);
        special    = div_zero || signed_ovf;
        accept     = (state == ST_IDLE) && start && !abort;
    end

`ifdef IDIVIDER_EARLY_TERM_EN
    localparam int LZW      = $clog2(DATA_WIDTH + 1);
    localparam int BPC_LOG2 = $clog2(BITS_PER_CYCLE);
    localparam logic [CW-1:0] ITER_COUNT = CW'(ITER);

    logic [LZW-1:0] lz;
    logic [LZW-1:0] lz_aligned;
    logic           lz_found;

    // Leading zeros of |a| are quotient bits known to be zero; skip whole cycles of them.
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (abs_a[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + 1'b1;
                end
            end
        end
        lz_aligned  = (lz >> BPC_LOG2) << BPC_LOG2;
        start_count = CW'(lz >> BPC_LOG2);
        start_qsr   = abs_a << lz_aligned;
        early_zero  = (start_count == ITER_COUNT);
    end
`else
    always_comb begin
        start_count = '0;
        start_qsr   = abs_a;
        early_zero  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept && !special) begin
                    next_state = early_zero ? ST_SIGN : ST_CALC;
                end
            end
            ST_CALC: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (count == LAST_COUNT) begin
                    next_state = ST_SIGN;
                end
            end
            ST_SIGN: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != ST_IDLE);
        load         = accept && !special;
        special_done = accept && special;
        calc_en      = (state == ST_CALC) && !abort;
        finish       = (state == ST_SIGN) && !abort;
    end

    // Restoring step chain: each stage consumes one quotient MSB and yields one quotient bit.
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        logic [DATA_WIDTH-1:0] rem_in, qsr_in, rem_out, qsr_out;
        logic                  q_bit;

        if (g == 0) begin : g_first
            assign rem_in = remainder;
            assign qsr_in = quotient_sr;
        end else begin : g_next
            assign rem_in = g_step[g-1].rem_out;
            assign qsr_in = g_step[g-1].qsr_out;
        end

        idivider_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
            .remainder      (rem_in),
            .quotient_msb   (qsr_in[DATA_WIDTH-1]),
            .divisor        (divisor_r),
            .remainder_next (rem_out),
            .quotient_bit   (q_bit)
        );

        assign qsr_out = {qsr_in[DATA_WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quotient_sr  <= '0;
            remainder    <= '0;
            divisor_r    <= '0;
            count        <= '0;
            dividend_neg <= 1'b0;
            divisor_neg  <= 1'b0;
            y_quotient   <= '0;
            y_remainder  <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dividend_neg <= a_neg;
                divisor_neg  <= b_neg;
            end
            if (special_done) begin
                y_quotient  <= div_zero ? ALL_ONES : SIGNED_MIN;
                y_remainder <= div_zero ? a : '0;
                done        <= 1'b1;
            end
            if (load) begin
                quotient_sr <= start_qsr;
                divisor_r   <= abs_b;
                remainder   <= '0;
                count       <= start_count;
            end
            if (calc_en) begin
                quotient_sr <= g_step[BITS_PER_CYCLE-1].qsr_out;
                remainder   <= g_step[BITS_PER_CYCLE-1].rem_out;
                count       <= count + 1'b1;
            end
            if (finish) begin
                y_quotient  <= (dividend_neg ^ divisor_neg) ? -quotient_sr : quotient_sr;
                y_remainder <= dividend_neg ? -remainder : remainder;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_idivider_radix.sv
// tb/tb_idivider_radix.sv - randomized self-checking bench for idivider_radix at 1/2/4 bits per cycle
module tb_idivider_radix;

    logic        clk;
    logic        reset_n;
    logic [31:0] a, b;
    logic        is_signed, start, abort;
    logic [2:0]  busy_w, done_w;
    logic [31:0] q_w [3];
    logic [31:0] r_w [3];

    int total = 0;
    int bad   = 0;
    logic [31:0] last_q, last_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    idivider_radix #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) dut_b1 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .is_signed(is_signed),
        .start(start), .abort(abort), .busy(busy_w[0]), .y_quotient(q_w[0]),
        .y_remainder(r_w[0]), .done(done_w[0]));

    idivider_radix #(.DATA_WIDTH(32), .BITS_PER_CYCLE(2)) dut_b2 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .is_signed(is_signed),
        .start(start), .abort(abort), .busy(busy_w[1]), .y_quotient(q_w[1]),
        .y_remainder(r_w[1]), .done(done_w[1]));

    idivider_radix #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) dut_b4 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .is_signed(is_signed),
        .start(start), .abort(abort), .busy(busy_w[2]), .y_quotient(q_w[2]),
        .y_remainder(r_w[2]), .done(done_w[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int bpc_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
        int sx, sy;
        sx = x;
        sy = y;
        if (y == 0)                                        return {32'hFFFF_FFFF, x};
        if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        if (s) return {32'(sx / sy), 32'(sx % sy)};
        return {x / y, x % y};
    endfunction

    function automatic int ref_latency(input logic [31:0] x, input logic [31:0] y,
                                       input logic s, input int bpc);
        logic [31:0] mag;
        int          lz;
        if (y == 0 || (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
        mag = (s && x[31]) ? -x : x;
        lz  = 0;
        while (lz < 32 && mag[31-lz] == 1'b0) lz++;
`ifdef IDIVIDER_EARLY_TERM_EN
        return 32 / bpc - lz / bpc + 2;
`else
        if (lz < 0) return 0;
        return 32 / bpc + 2;
`endif
    endfunction

    // poke > 0 pulses a conflicting start at that cycle, while every instance is still busy.
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts, input int poke);
        logic [63:0] exp;
        int          lat [3];
        int          bcnt [3];
        int          dcnt [3];
        logic [31:0] gq [3];
        logic [31:0] gr [3];
        exp = ref_div(ta, tb_v, ts);
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0; bcnt[i] = 0; dcnt[i] = 0; gq[i] = 'x; gr[i] = 'x;
        end
        @(negedge clk);
        a = ta; b = tb_v; is_signed = ts; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (busy_w[i]) bcnt[i]++;
                if (done_w[i]) begin
                    dcnt[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = k; gq[i] = q_w[i]; gr[i] = r_w[i];
                    end
                end
            end
            if (k == 1) start = 1'b0;
            if (poke > 0 && k == poke) begin
                start = 1'b1; a = ~ta; b = 32'd5;
            end
            if (poke > 0 && k == poke + 1) start = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            int el;
            el = ref_latency(ta, tb_v, ts, bpc_of(i));
            check_val($sformatf("quot_b%0d a=%08h b=%08h s=%0d", bpc_of(i), ta, tb_v, ts), gq[i], exp[63:32]);
            check_val($sformatf("rem_b%0d a=%08h b=%08h s=%0d", bpc_of(i), ta, tb_v, ts), gr[i], exp[31:0]);
            check_val($sformatf("latency_b%0d", bpc_of(i)), 32'(lat[i]), 32'(el));
            check_val($sformatf("busy_cycles_b%0d", bpc_of(i)), 32'(bcnt[i]), 32'(el - 1));
            check_val($sformatf("done_pulses_b%0d", bpc_of(i)), 32'(dcnt[i]), 32'd1);
        end
        last_q = exp[63:32];
        last_r = exp[31:0];
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done_w != 3'b000) seen++;
        end
        check_val(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        reset_n = 1'b0; a = '0; b = '0; is_signed = 1'b0; start = 1'b0; abort = 1'b0;
        last_q = '0; last_r = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("reset_busy_b%0d", bpc_of(i)), 32'(busy_w[i]), 32'd0);
            check_val($sformatf("reset_done_b%0d", bpc_of(i)), 32'(done_w[i]), 32'd0);
            check_val($sformatf("reset_quot_b%0d", bpc_of(i)), q_w[i], 32'd0);
            check_val($sformatf("reset_rem_b%0d", bpc_of(i)), r_w[i], 32'd0);
        end
        reset_n = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0);
        run_div(32'd5, 32'd0, 1'b0, 0);
        run_div(32'd5, 32'd0, 1'b1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_div(32'hFFFF_FFFF, 32'd3, 1'b0, 0);
        run_div(32'd1, 32'd1, 1'b0, 0);
        run_div(32'd0, 32'd3, 1'b0, 0);
        run_div(32'h8000_0000, 32'd1, 1'b1, 0);
        run_div(32'hF000_0000, 32'd11, 1'b0, 3);

        // Abort mid-CALC: no completion, outputs keep the previous result.
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'd3; is_signed = 1'b0; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check_val("abort_pre_done", 32'(done_w), 32'd0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_busy", 32'(busy_w), 32'd0);
        check_val("abort_done", 32'(done_w), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("abort_quot_b%0d", bpc_of(i)), q_w[i], last_q);
            check_val($sformatf("abort_rem_b%0d", bpc_of(i)), r_w[i], last_r);
        end
        run_div(32'd9, 32'd4, 1'b0, 0);

        // abort outranks start in IDLE
        @(negedge clk);
        a = 32'd50; b = 32'd6; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_val("abort_prio_busy", 32'(busy_w), 32'd0);
        watch_no_done("abort_prio_no_done", 5);

        // Reset mid-CALC discards the division and clears outputs.
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'd7; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_busy", 32'(busy_w), 32'd0);
        check_val("rst_mid_done", 32'(done_w), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst_mid_quot_b%0d", bpc_of(i)), q_w[i], 32'd0);
            check_val($sformatf("rst_mid_rem_b%0d", bpc_of(i)), r_w[i], 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        watch_no_done("rst_mid_no_done", 40);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rs = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0: rb = $urandom_range(1, 15);
                1: rb = '0;
                2: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = $urandom_range(0, 300);
            run_div(ra, rb, rs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
